// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus master and its peripherals.
// Polling support is enabled by defining MMIO_POLL_EN.
package mmio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StGap,
    StResp
  } state_e;

  localparam logic [31:0] TimerCntAddr    = 32'hFFFF_F100;
  localparam logic [31:0] TimerLimitAddr  = 32'hFFFF_F104;
  localparam logic [31:0] TimerCtrlAddr   = 32'hFFFF_F108;
  localparam logic [31:0] IdleAddrDefault = 32'h0000_0000;

  // One extra bit so the counter can never wrap within POLL_MAX reads.
  function automatic int unsigned poll_cnt_width(input int unsigned poll_max);
    return $clog2(poll_max) + 1;
  endfunction

endpackage

// File: rtl/mmio_bus_master_if.sv
// Request/response and peripheral-bus signals of the MMIO bus master.
// The master modport is the initiator; slave is the core plus peripherals.
interface mmio_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_poll;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [31:0] abus;
  logic        we;
  logic [31:0] dbuso;
  logic [31:0] dbusi;

  modport master (
    input  req_valid, req_we, req_poll, req_addr, req_wdata, req_mask, rsp_ready, dbusi,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, abus, we, dbuso
  );

  modport slave (
    output req_valid, req_we, req_poll, req_addr, req_wdata, req_mask, rsp_ready, dbusi,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, abus, we, dbuso
  );
endinterface

// File: rtl/mmio_bus_master.sv
// Single-request MMIO initiator with optional hardware polling (MMIO_POLL_EN):
// re-reads an address, one idle bus cycle apart, until masked bits set or POLL_MAX reads.
module mmio_bus_master
  import mmio_pkg::*;
#(
  parameter int unsigned POLL_MAX  = 1024,
  parameter logic [31:0] IDLE_ADDR = IdleAddrDefault
) (
  input logic              i_clk,
  input logic              i_reset,
  mmio_bus_master_if.master io_bus
);

  state_e      r_state, w_state_d;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_data, w_rsp_data_d;
  logic        w_accept;

`ifdef MMIO_POLL_EN
  localparam int unsigned   CntW    = poll_cnt_width(POLL_MAX);
  localparam logic [CntW-1:0] CntLast = CntW'(POLL_MAX - 1);

  logic            r_poll;
  logic [31:0]     r_mask;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_rsp_timeout, w_rsp_timeout_d;
  logic            w_hit;

  assign w_hit = |(io_bus.dbusi & r_mask);
  assign io_bus.rsp_timeout = r_rsp_timeout;
`else
  logic w_unused;
  assign w_unused = ^{io_bus.req_poll, io_bus.req_mask, (POLL_MAX == 0)};
  assign io_bus.rsp_timeout = 1'b0;
`endif

  assign io_bus.rsp_data = r_rsp_data;

  always_comb begin
    w_state_d        = r_state;
    w_rsp_data_d     = r_rsp_data;
    w_accept         = 1'b0;
    io_bus.req_ready = 1'b0;
    io_bus.rsp_valid = 1'b0;
    io_bus.abus      = IDLE_ADDR;
    io_bus.we        = 1'b0;
    io_bus.dbuso     = '0;
`ifdef MMIO_POLL_EN
    w_cnt_d          = r_cnt;
    w_rsp_timeout_d  = r_rsp_timeout;
`endif
    unique case (r_state)
      StIdle: begin
        io_bus.req_ready = 1'b1;
        if (io_bus.req_valid) begin
          w_accept  = 1'b1;
          w_state_d = StAccess;
`ifdef MMIO_POLL_EN
          w_cnt_d   = '0;
`endif
        end
      end
      StAccess: begin
        io_bus.abus  = r_addr;
        io_bus.we    = r_we;
        io_bus.dbuso = r_we ? r_wdata : '0;
        w_state_d    = StResp;
        w_rsp_data_d = r_we ? '0 : io_bus.dbusi;
`ifdef MMIO_POLL_EN
        w_rsp_timeout_d = 1'b0;
        if (!r_we && r_poll && !w_hit) begin
          if (r_cnt == CntLast) begin
            w_rsp_timeout_d = 1'b1;
          end else begin
            w_cnt_d   = r_cnt + CntW'(1);
            w_state_d = StGap;
          end
        end
`endif
      end
`ifdef MMIO_POLL_EN
      // Idle bus cycle keeps consecutive polls distinct for read-sensitive devices.
      StGap: w_state_d = StAccess;
`endif
      StResp: begin
        io_bus.rsp_valid = 1'b1;
        if (io_bus.rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
`ifdef MMIO_POLL_EN
      r_poll        <= 1'b0;
      r_mask        <= '0;
      r_cnt         <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_rsp_data <= w_rsp_data_d;
      if (w_accept) begin
        r_we    <= io_bus.req_we;
        r_addr  <= io_bus.req_addr;
        r_wdata <= io_bus.req_wdata;
      end
`ifdef MMIO_POLL_EN
      r_cnt         <= w_cnt_d;
      r_rsp_timeout <= w_rsp_timeout_d;
      if (w_accept) begin
        r_poll <= io_bus.req_poll & ~io_bus.req_we;
        r_mask <= io_bus.req_mask;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Directed bench for mmio_bus_master with a small timer peripheral model.
// Expectations follow the MMIO_POLL_EN setting of the build.
module tb_mmio_bus_master;
  import mmio_pkg::*;

  localparam logic [31:0] Unmapped = 32'hFFFF_F300;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mmio_bus_master_if bus ();

  mmio_bus_master #(
    .POLL_MAX (4),
    .IDLE_ADDR(32'h0000_0000)
  ) dut (
    .i_clk (clk),
    .i_reset(rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer: a limit write restarts counting; TCTL bit0 sets after 'limit' cycles and sticks.
  logic [31:0] t_cnt, t_lim;
  logic        t_ctl;

  always @(posedge clk) begin
    if (rst) begin
      t_cnt <= '0;
      t_lim <= '0;
      t_ctl <= 1'b0;
    end else if (bus.we && bus.abus == TimerLimitAddr) begin
      t_lim <= bus.dbuso;
      t_cnt <= '0;
      t_ctl <= 1'b0;
    end else if (!t_ctl && t_lim != 0) begin
      if (t_cnt == t_lim - 1) begin
        t_ctl <= 1'b1;
        t_cnt <= '0;
      end else begin
        t_cnt <= t_cnt + 1;
      end
    end
  end

  always_comb begin
    bus.dbusi = '0;
    if (!bus.we) begin
      case (bus.abus)
        TimerCntAddr:   bus.dbusi = t_cnt;
        TimerLimitAddr: bus.dbusi = t_lim;
        TimerCtrlAddr:  bus.dbusi = {31'b0, t_ctl};
        default:        bus.dbusi = '0;
      endcase
    end
  end

  // Issues one request from a negedge and observes it until the response handshake.
  task automatic do_req(input logic we, input logic poll, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mask,
                        output int lat, output int n_acc, output int n_we, output bit b2b,
                        output logic [31:0] acc_addr, output logic [31:0] acc_dbuso,
                        output logic [31:0] data, output logic tmo);
    bit prev, cur;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_poll  = poll;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_mask  = mask;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; n_acc = 0; n_we = 0; b2b = 0; prev = 0;
    acc_addr = '0; acc_dbuso = '0;
    while (!bus.rsp_valid && lat < 200) begin
      cur = (bus.abus != 32'h0) || bus.we || (bus.dbuso != 32'h0);
      if (cur) begin
        n_acc++;
        acc_addr  = bus.abus;
        acc_dbuso = bus.dbuso;
        if (bus.we) n_we++;
        if (prev) b2b = 1;
      end
      prev = cur;
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) lat = -1;
    data = bus.rsp_data;
    tmo  = bus.rsp_timeout;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  int          lat, n_acc, n_we;
  bit          b2b;
  logic [31:0] acc_addr, acc_dbuso, data;
  logic        tmo;

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_poll = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_mask = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++;
      $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== 32'h0) begin n_errors++;
      $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
    n_checks++; if (bus.rsp_timeout !== 1'b0) begin n_errors++;
      $display("FAIL reset_rsp_timeout got %b want 0", bus.rsp_timeout); end
    n_checks++; if (bus.abus !== 32'h0) begin n_errors++;
      $display("FAIL reset_abus got %h want 0", bus.abus); end
    n_checks++; if (bus.we !== 1'b0 || bus.dbuso !== 32'h0) begin n_errors++;
      $display("FAIL reset_we_dbuso got %b/%h want 0/0", bus.we, bus.dbuso); end
  endtask

  task automatic test_write();
    do_req(1'b1, 1'b0, TimerLimitAddr, 32'hA, 32'h0, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
    n_checks++; if (lat != 2) begin n_errors++;
      $display("FAIL write_latency got %0d want 2", lat); end
    n_checks++; if (n_acc != 1 || n_we != 1) begin n_errors++;
      $display("FAIL write_cycles got acc=%0d we=%0d want 1/1", n_acc, n_we); end
    n_checks++; if (acc_addr !== TimerLimitAddr || acc_dbuso !== 32'hA) begin n_errors++;
      $display("FAIL write_bus got %h/%h want fffff104/a", acc_addr, acc_dbuso); end
    n_checks++; if (data !== 32'h0 || tmo !== 1'b0) begin n_errors++;
      $display("FAIL write_rsp got %h/%b want 0/0", data, tmo); end
    n_checks++; if (t_lim !== 32'hA) begin n_errors++;
      $display("FAIL write_commit got %h want a", t_lim); end
  endtask

  task automatic test_read();
    do_req(1'b0, 1'b0, TimerLimitAddr, 32'hFFFF_FFFF, 32'h0, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
    n_checks++; if (data !== 32'hA || tmo !== 1'b0) begin n_errors++;
      $display("FAIL read_rsp got %h/%b want a/0", data, tmo); end
    n_checks++; if (lat != 2 || n_acc != 1 || n_we != 0) begin n_errors++;
      $display("FAIL read_cycles got lat=%0d acc=%0d we=%0d want 2/1/0", lat, n_acc, n_we); end
    n_checks++; if (acc_dbuso !== 32'h0) begin n_errors++;
      $display("FAIL read_dbuso got %h want 0", acc_dbuso); end
    // Write with poll set behaves as a plain write.
    do_req(1'b1, 1'b1, TimerLimitAddr, 32'h1234_5678, 32'h0, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
    do_req(1'b0, 1'b0, TimerLimitAddr, 32'h0, 32'h0, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
    n_checks++; if (data !== 32'h1234_5678) begin n_errors++;
      $display("FAIL read_pattern got %h want 12345678", data); end
  endtask

  task automatic test_poll();
    do_req(1'b1, 1'b0, TimerLimitAddr, 32'h3, 32'h0, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
    do_req(1'b0, 1'b1, TimerCtrlAddr, 32'h0, 32'h1, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
`ifdef MMIO_POLL_EN
    n_checks++; if (data !== 32'h1 || tmo !== 1'b0) begin n_errors++;
      $display("FAIL poll_rsp got %h/%b want 1/0", data, tmo); end
    n_checks++; if (n_acc != 2 || lat != 4) begin n_errors++;
      $display("FAIL poll_cycles got acc=%0d lat=%0d want 2/4", n_acc, lat); end
`else
    n_checks++; if (data !== 32'h0 || tmo !== 1'b0) begin n_errors++;
      $display("FAIL poll_rsp got %h/%b want 0/0", data, tmo); end
    n_checks++; if (n_acc != 1 || lat != 2) begin n_errors++;
      $display("FAIL poll_cycles got acc=%0d lat=%0d want 1/2", n_acc, lat); end
`endif
    n_checks++; if (b2b || n_we != 0) begin n_errors++;
      $display("FAIL poll_gap got b2b=%0b we=%0d want 0/0", b2b, n_we); end
  endtask

  task automatic test_poll_timeout();
    do_req(1'b0, 1'b1, Unmapped, 32'h0, 32'h1, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
`ifdef MMIO_POLL_EN
    n_checks++; if (lat != 8 || n_acc != 4) begin n_errors++;
      $display("FAIL timeout_cycles got lat=%0d acc=%0d want 8/4", lat, n_acc); end
    n_checks++; if (tmo !== 1'b1 || data !== 32'h0) begin n_errors++;
      $display("FAIL timeout_rsp got %b/%h want 1/0", tmo, data); end
`else
    n_checks++; if (lat != 2 || n_acc != 1) begin n_errors++;
      $display("FAIL timeout_cycles got lat=%0d acc=%0d want 2/1", lat, n_acc); end
    n_checks++; if (tmo !== 1'b0 || data !== 32'h0) begin n_errors++;
      $display("FAIL timeout_rsp got %b/%h want 0/0", tmo, data); end
`endif
    n_checks++; if (b2b) begin n_errors++;
      $display("FAIL timeout_gap got b2b=1 want 0"); end
    // Zero mask never matches, even though TCTL bit0 is set.
    do_req(1'b0, 1'b1, TimerCtrlAddr, 32'h0, 32'h0, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
`ifdef MMIO_POLL_EN
    n_checks++; if (lat != 8 || n_acc != 4 || tmo !== 1'b1 || data !== 32'h1) begin n_errors++;
      $display("FAIL mask0 got lat=%0d acc=%0d tmo=%b data=%h want 8/4/1/1",
               lat, n_acc, tmo, data); end
`else
    n_checks++; if (lat != 2 || n_acc != 1 || tmo !== 1'b0 || data !== 32'h1) begin n_errors++;
      $display("FAIL mask0 got lat=%0d acc=%0d tmo=%b data=%h want 2/1/0/1",
               lat, n_acc, tmo, data); end
`endif
  endtask

  task automatic test_resp_hold();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_poll = 1'b0;
    bus.req_addr = TimerLimitAddr; bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h3) begin n_errors++;
        $display("FAIL hold_rsp[%0d] got %b/%h want 1/3", i, bus.rsp_valid, bus.rsp_data); end
      n_checks++; if (bus.req_ready !== 1'b0) begin n_errors++;
        $display("FAIL hold_req_ready[%0d] got %b want 0", i, bus.req_ready); end
      n_checks++; if (bus.abus !== 32'h0 || bus.we !== 1'b0 || bus.dbuso !== 32'h0) begin
        n_errors++;
        $display("FAIL hold_bus[%0d] got %h/%b/%h want 0/0/0", i, bus.abus, bus.we, bus.dbuso);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_errors++;
      $display("FAIL hold_release got %b/%b want 1/0", bus.req_ready, bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 1'b0, TimerLimitAddr, 32'h5, 32'h0, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++;
      $display("FAIL b2b_idle got %b want 1", bus.req_ready); end
    do_req(1'b0, 1'b0, TimerLimitAddr, 32'h0, 32'h0, lat, n_acc, n_we, b2b,
           acc_addr, acc_dbuso, data, tmo);
    n_checks++; if (lat != 2 || data !== 32'h5) begin n_errors++;
      $display("FAIL b2b_read got lat=%0d data=%h want 2/5", lat, data); end
  endtask

  task automatic test_reset_gap();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_poll = 1'b1;
    bus.req_addr = Unmapped; bus.req_mask = 32'h1; bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_errors++;
      $display("FAIL rst_gap_state got %b/%b want 1/0", bus.req_ready, bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== 32'h0 || bus.rsp_timeout !== 1'b0) begin n_errors++;
      $display("FAIL rst_gap_rsp got %h/%b want 0/0", bus.rsp_data, bus.rsp_timeout); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.abus !== 32'h0 || bus.we !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_gap_quiet[%0d] got %b/%h/%b want 0/0/0",
                 i, bus.rsp_valid, bus.abus, bus.we);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_poll();
    test_poll_timeout();
    test_resp_hold();
    test_back_to_back();
    test_reset_gap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_bus_master.md
# mmio_bus_master

Initiator side of the processor's memory-mapped I/O bus: accepts single read/write requests from the core's memory stage and drives ABUS/WE/write data toward the peripherals (timer, keys, LEDs, ...). It captures the OR-ed read-data return. It optionally performs hardware polling: it re-reads an address until masked bits are set or an iteration limit expires. This lets the core wait on a peripheral flag, such as the timer's TCTL ready bit, without a software loop.

## Interface
- POLL_MAX, 1024: maximum bus reads in one poll request; must be ≥1.
- IDLE_ADDR, 32'h0000_0000: address driven when the bus is idle; must decode to no device.

- CLK  in  1  system clock, all logic on posedge
- RESET  in  1  synchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  block can accept a request
- REQ_WE  in  1  1 = write, 0 = read
- REQ_POLL  in  1  read with polling (ignored when REQ_WE=1)
- REQ_ADDR  in  32  target address
- REQ_WDATA  in  32  write data
- REQ_MASK  in  32  poll condition mask
- RSP_VALID  out  1  response present
- RSP_READY  in  1  core accepts the response
- RSP_DATA  out  32  read data (0 for writes)
- RSP_TIMEOUT  out  1  poll ended without the condition being met
- ABUS  out  32  bus address to peripherals
- WE  out  1  bus write enable
- DBUSO  out  32  write data to peripherals (their data-in)
- DBUSI  in  32  OR-ed read data from peripherals, combinational in ABUS/WE

## Operation
- FSM states: IDLE, ACCESS, GAP, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, latch WE, POLL, ADDR, WDATA and MASK; clear the poll counter; go to ACCESS.
- ACCESS:
  - ABUS=addr, WE=we, DBUSO=we?wdata:0; asserted for exactly one cycle.
  - Write: the peripheral commits at the end of this cycle; RSP_DATA←0; go to RESP.
  - Read: RSP_DATA←DBUSI, sampled at the end of this cycle.
  - Non-poll read: go to RESP.
  - Poll read, (DBUSI & mask)≠0: go to RESP, RSP_TIMEOUT=0.
  - Poll read, condition false and counter = POLL_MAX-1: go to RESP, RSP_TIMEOUT=1.
  - Poll read, otherwise: counter+1, go to GAP.
- GAP:
  - Bus idle for one cycle (ABUS=IDLE_ADDR, WE=0, DBUSO=0); go to ACCESS.
  - The gap guarantees distinct bus transactions for read-sensitive peripherals.
- RESP:
  - RSP_VALID=1; RSP_DATA and RSP_TIMEOUT held stable.
  - On RSP_READY go to IDLE.
- Mask of 0 in poll mode: the condition is never true, so the request always times out after POLL_MAX reads.
- Poll counter width: $clog2(POLL_MAX)+1; no wrap-around possible.
- Bus outputs outside ACCESS: IDLE_ADDR/0/0.

## Timing
- Reset values:
  - State IDLE.
  - REQ_READY=1 from the first cycle after reset.
  - RSP_VALID=0, RSP_DATA=0, RSP_TIMEOUT=0.
  - ABUS=IDLE_ADDR, WE=0, DBUSO=0.
- Request accepted in cycle N; ACCESS in cycle N+1; RSP_VALID first high in N+2.
- Poll: each extra iteration costs 2 cycles. A timeout response appears at N+2·POLL_MAX.
- Back-to-back: after RESP handshake in cycle M, IDLE in M+1; next ACCESS is no earlier than M+2.
- REQ_READY is combinational from state only; there is no REQ_VALID→REQ_READY path.
- Reset asserted in any state:
  - Next cycle in IDLE with reset values.
  - The in-flight request is dropped without a response.
  - A write whose ACCESS cycle coincides with reset still drives WE that cycle. Peripherals share the same reset.

## Configuration
- MMIO_POLL_EN defined: polling as described; GAP state and counter present.
- MMIO_POLL_EN undefined:
  - REQ_POLL and REQ_MASK are ignored; all reads are single-shot.
  - RSP_TIMEOUT is tied 0; GAP and the counter are not synthesized.
  - POLL_MAX is unused.

## Structure
- Shared package `mmio_pkg`:
  - State enum.
  - Peripheral address constants: timer count FFFFF100, limit FFFFF104, control FFFFF108.
  - IDLE_ADDR default.
- Single module; no sub-module. An optional `mmio_poll_ctr` split is not warranted.

## Test plan
- Write 0x0000000A to FFFFF104 → ABUS=FFFFF104, WE=1, DBUSO=0xA for exactly one cycle; RSP_VALID at N+2 with RSP_DATA=0; timer limit reads back 0xA.
- Read FFFFF104 after the above → RSP_DATA=0x0000000A, RSP_TIMEOUT=0, WE=0 throughout.
- Poll FFFFF108, mask 0x1, timer limit 3 → repeated reads with an idle cycle between each; terminates when TCTL bit0 sets; RSP_DATA bit0=1, RSP_TIMEOUT=0.
- Poll an unmapped address (DBUSI=0), POLL_MAX=4 → exactly 4 ACCESS cycles; RSP_TIMEOUT=1, RSP_DATA=0 at cycle N+8.
- Hold RSP_READY low 5 cycles → RSP_VALID/RSP_DATA stable; REQ_READY=0; no bus activity.
- Assert RESET during GAP of a poll → next cycle IDLE, REQ_READY=1, no RSP_VALID, ABUS=IDLE_ADDR.
